// File: rtl/otter_pkg.sv
// Shared types and constants for the OTTER fetch front end.
// pc_sel encodings, sequencer states and the reset vector.
package otter_pkg;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;

    typedef enum logic [2:0] {
        PC_PLUS4  = 3'd0,
        PC_JALR   = 3'd1,
        PC_BRANCH = 3'd2,
        PC_JAL    = 3'd3,
        PC_MTVEC  = 3'd4,
        PC_MEPC   = 3'd5
    } pc_sel_t;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        PEND  = 2'd2
    } seq_state_t;

    // Only selects 1..5 change control flow; 0, 6 and 7 mean PC+4.
    function automatic logic is_redirect(input logic [2:0] sel);
        return (sel >= 3'd1) && (sel <= 3'd5);
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC target selection and alignment for pc_sequencer.
// OTTER_MISALIGN_TRAP_EN: misaligned targets divert to mtvec.
module pc_next_mux
    import otter_pkg::*;
(
    input  logic [2:0]  sel,
    input  logic [31:0] pc,
    input  logic [31:0] jal,
    input  logic [31:0] branch,
    input  logic [31:0] jalr,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic [31:0] pend,
    input  logic        use_pend,
    output logic [31:0] raw,
    output logic [31:0] tgt
`ifdef OTTER_MISALIGN_TRAP_EN
    ,
    output logic        misal
`endif
);

    logic [31:0] chosen;

    always_comb begin
        raw = pc + 32'd4;
        case (sel)
            PC_JALR:   raw = jalr;
            PC_BRANCH: raw = branch;
            PC_JAL:    raw = jal;
            PC_MTVEC:  raw = mtvec;
            PC_MEPC:   raw = mepc;
            default:   raw = pc + 32'd4;
        endcase
    end

    assign chosen = use_pend ? pend : raw;

`ifdef OTTER_MISALIGN_TRAP_EN
    assign misal = |chosen[1:0];
    assign tgt   = misal ? mtvec : chosen;
`else
    assign tgt   = chosen & ~32'h3;
`endif

endmodule

// File: rtl/pc_sequencer.sv
// PC register and fetch-request sequencer with deferred redirects.
// OTTER_MISALIGN_TRAP_EN adds the misalign_trap output.
module pc_sequencer
    import otter_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        redirect_valid,
    input  logic [2:0]  pc_sel,
    input  logic [31:0] jal,
    input  logic [31:0] branch,
    input  logic [31:0] jalr,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic        stall,
    input  logic        fetch_ready,
    output logic        fetch_valid,
    output logic [31:0] fetch_addr,
    output logic [31:0] pc_out,
    output logic        fetch_flush,
    output logic        redirect_pending
`ifdef OTTER_MISALIGN_TRAP_EN
    ,
    output logic        misalign_trap
`endif
);

    seq_state_t  state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] pend, pend_n;
    logic        req_out, req_n;
    logic        flush, flush_n;
    logic        redir, hs, use_pend;
    logic [2:0]  sel_eff;
    logic [31:0] raw, tgt;
`ifdef OTTER_MISALIGN_TRAP_EN
    logic        misal, trap, trap_n;
`endif

    // req_out keeps a presented request alive across stall/redirect.
    assign fetch_valid = (state != BOOT) && (req_out || !stall);
    assign hs          = fetch_valid && fetch_ready;
    assign redir       = redirect_valid && is_redirect(pc_sel);
    assign sel_eff     = redir ? pc_sel : 3'(PC_PLUS4);
    assign use_pend    = (state == PEND) && !redir;

    pc_next_mux u_mux (
        .sel      (sel_eff),
        .pc       (pc),
        .jal      (jal),
        .branch   (branch),
        .jalr     (jalr),
        .mtvec    (mtvec),
        .mepc     (mepc),
        .pend     (pend),
        .use_pend (use_pend),
        .raw      (raw),
        .tgt      (tgt)
`ifdef OTTER_MISALIGN_TRAP_EN
        ,
        .misal    (misal)
`endif
    );

    always_comb begin
        state_n = state;
        pc_n    = pc;
        pend_n  = pend;
        flush_n = 1'b0;
        req_n   = fetch_valid && !fetch_ready;
`ifdef OTTER_MISALIGN_TRAP_EN
        trap_n  = 1'b0;
`endif
        case (state)
            BOOT: begin
                state_n = FETCH;
            end
            FETCH: begin
                if (hs) begin
                    pc_n = tgt;
`ifdef OTTER_MISALIGN_TRAP_EN
                    trap_n = misal;
`endif
                end else if (redir) begin
                    pend_n  = raw;
                    state_n = PEND;
                end
            end
            PEND: begin
                // A same-cycle redirect beats the captured one via use_pend.
                if (hs) begin
                    pc_n    = tgt;
                    flush_n = 1'b1;
                    state_n = FETCH;
`ifdef OTTER_MISALIGN_TRAP_EN
                    trap_n  = misal;
`endif
                end else if (redir) begin
                    pend_n = raw;
                end
            end
            default: begin
                state_n = BOOT;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= BOOT;
            pc      <= RESET_VEC;
            pend    <= 32'h0;
            req_out <= 1'b0;
            flush   <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            pend    <= pend_n;
            req_out <= req_n;
            flush   <= flush_n;
        end
    end

`ifdef OTTER_MISALIGN_TRAP_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) trap <= 1'b0;
        else        trap <= trap_n;
    end

    assign misalign_trap = trap;
`endif

    assign fetch_addr       = pc;
    assign pc_out           = pc;
    assign fetch_flush      = flush;
    assign redirect_pending = (state == PEND);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer.
// Honours OTTER_MISALIGN_TRAP_EN for the misaligned-target case.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [2:0]  pc_sel = 3'd0;
    logic [31:0] jal = 32'h200;
    logic [31:0] branch = 32'h300;
    logic [31:0] jalr = 32'h102;
    logic [31:0] mtvec = 32'h80;
    logic [31:0] mepc = 32'h40;
    logic        stall = 1'b0;
    logic        fetch_ready = 1'b0;
    logic        fetch_valid;
    logic [31:0] fetch_addr;
    logic [31:0] pc_out;
    logic        fetch_flush;
    logic        redirect_pending;
`ifdef OTTER_MISALIGN_TRAP_EN
    logic        misalign_trap;
    localparam logic [31:0] MIS_PC = 32'h80;
    localparam logic        MIS_TRAP = 1'b1;
`else
    localparam logic [31:0] MIS_PC = 32'h100;
    localparam logic        MIS_TRAP = 1'b0;
`endif

    int total = 0;
    int passed = 0;

    pc_sequencer dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .redirect_valid   (redirect_valid),
        .pc_sel           (pc_sel),
        .jal              (jal),
        .branch           (branch),
        .jalr             (jalr),
        .mtvec            (mtvec),
        .mepc             (mepc),
        .stall            (stall),
        .fetch_ready      (fetch_ready),
        .fetch_valid      (fetch_valid),
        .fetch_addr       (fetch_addr),
        .pc_out           (pc_out),
        .fetch_flush      (fetch_flush),
        .redirect_pending (redirect_pending)
`ifdef OTTER_MISALIGN_TRAP_EN
        ,
        .misalign_trap    (misalign_trap)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rv;
        logic [2:0]  sel;
        logic [31:0] jal;
        logic        stall;
        logic        rdy;
        logic        ev;
        logic [31:0] ea;
        logic        ep;
        logic        ef;
        logic        et;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rv, input logic [2:0] sel, input logic [31:0] j,
        input logic st, input logic rdy, input logic ev,
        input logic [31:0] ea, input logic ep, input logic ef,
        input logic et);
        vec_t v;
        v.rv = rv; v.sel = sel; v.jal = j; v.stall = st; v.rdy = rdy;
        v.ev = ev; v.ea = ea; v.ep = ep; v.ef = ef; v.et = et;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [2:0] sel,
                         input logic [31:0] j, input logic rdy);
        redirect_valid = rv;
        pc_sel = sel;
        jal = j;
        fetch_ready = rdy;
    endtask

    initial begin
        // rv sel jal stall rdy | valid addr pend flush trap
        tbl.push_back(mk(0, 0, 32'h200, 0, 1, 0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h200, 0, 1, 1, 32'h0,   0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h200, 0, 1, 1, 32'h4,   0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h200, 0, 1, 1, 32'h8,   0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h200, 0, 1, 1, 32'hC,   0, 0, 0));
        tbl.push_back(mk(1, 3, 32'h200, 0, 0, 1, 32'h10,  0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h200, 0, 0, 1, 32'h10,  1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h200, 0, 1, 1, 32'h10,  1, 0, 0));
        tbl.push_back(mk(1, 3, 32'h200, 0, 0, 1, 32'h200, 0, 1, 0));
        tbl.push_back(mk(1, 2, 32'h200, 0, 0, 1, 32'h200, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h200, 0, 1, 1, 32'h200, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h200, 0, 1, 1, 32'h300, 0, 1, 0));
        tbl.push_back(mk(0, 0, 32'h200, 1, 1, 0, 32'h304, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h200, 1, 1, 0, 32'h304, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h200, 0, 0, 1, 32'h304, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h200, 1, 0, 1, 32'h304, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h200, 1, 1, 1, 32'h304, 0, 0, 0));
        tbl.push_back(mk(1, 3, 32'hFFFF_FFFC, 0, 1, 1, 32'h308, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h200, 0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h200, 0, 1, 1, 32'h0,   0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h200, 0, 0, 1, MIS_PC,  0, 0, MIS_TRAP));
        tbl.push_back(mk(1, 0, 32'h200, 0, 0, 1, MIS_PC,  0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h200, 0, 0, 1, MIS_PC,  0, 0, 0));
        tbl.push_back(mk(1, 6, 32'h200, 0, 1, 1, MIS_PC,  0, 0, 0));
        tbl.push_back(mk(1, 4, 32'h200, 0, 1, 1, MIS_PC + 32'd4, 0, 0, 0));
        tbl.push_back(mk(1, 5, 32'h200, 0, 1, 1, 32'h80,  0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h200, 0, 0, 1, 32'h40,  0, 0, 0));

        repeat (2) tick();
        chk("rst pc", pc_out, 32'h0);
        chk("rst valid", 32'(fetch_valid), 32'h0);
        chk("rst pend", 32'(redirect_pending), 32'h0);
        chk("rst flush", 32'(fetch_flush), 32'h0);
`ifdef OTTER_MISALIGN_TRAP_EN
        chk("rst trap", 32'(misalign_trap), 32'h0);
`endif
        RST_N = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rv, tbl[i].sel, tbl[i].jal, tbl[i].rdy);
            stall = tbl[i].stall;
            #1;
            chk($sformatf("v%0d valid", i), 32'(fetch_valid), 32'(tbl[i].ev));
            chk($sformatf("v%0d addr", i), fetch_addr, tbl[i].ea);
            chk($sformatf("v%0d pc", i), pc_out, tbl[i].ea);
            chk($sformatf("v%0d pend", i), 32'(redirect_pending), 32'(tbl[i].ep));
            chk($sformatf("v%0d flush", i), 32'(fetch_flush), 32'(tbl[i].ef));
`ifdef OTTER_MISALIGN_TRAP_EN
            chk($sformatf("v%0d trap", i), 32'(misalign_trap), 32'(tbl[i].et));
`endif
            tick();
        end

        // Redirect coinciding with the PEND handshake wins.
        drive(1, 3, 32'h500, 0);
        #1;
        chk("prio valid", 32'(fetch_valid), 32'h1);
        chk("prio addr0", fetch_addr, 32'h40);
        tick();
        drive(1, 2, 32'h200, 1);
        #1;
        chk("prio pend", 32'(redirect_pending), 32'h1);
        chk("prio addr1", fetch_addr, 32'h40);
        tick();
        drive(0, 0, 32'h200, 0);
        #1;
        chk("prio addr2", fetch_addr, 32'h300);
        chk("prio flush", 32'(fetch_flush), 32'h1);
        chk("prio pend2", 32'(redirect_pending), 32'h0);
        tick();

        // Reset during a pending redirect abandons everything at once.
        drive(1, 3, 32'h600, 0);
        tick();
        drive(0, 0, 32'h200, 0);
        #1;
        chk("mid pend", 32'(redirect_pending), 32'h1);
        chk("mid valid", 32'(fetch_valid), 32'h1);
        RST_N = 1'b0;
        #1;
        chk("mid rst pend", 32'(redirect_pending), 32'h0);
        chk("mid rst valid", 32'(fetch_valid), 32'h0);
        chk("mid rst pc", pc_out, 32'h0);
        chk("mid rst flush", 32'(fetch_flush), 32'h0);
        tick();
        RST_N = 1'b1;
        fetch_ready = 1'b1;
        #1;
        chk("boot valid", 32'(fetch_valid), 32'h0);
        tick();
        chk("post valid", 32'(fetch_valid), 32'h1);
        chk("post addr0", fetch_addr, 32'h0);
        tick();
        chk("post addr1", fetch_addr, 32'h4);
        chk("post pend", 32'(redirect_pending), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
